// File: rtl/c2c_pkg.sv
// c2c_pkg: shared definitions for the chip-to-chip link controllers.
//   state_t      - link FSM state encoding (IDLE, REQ, XFER, DONE)
//   C2C_DATA_W   - default encoded data width on the link
//   C2C_TIMEOUT  - default handshake timeout in clk cycles, shared with the
//                  slave-side controller so both ends abort on the same budget
package c2c_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int C2C_DATA_W  = 3;
  localparam int C2C_TIMEOUT = 1_000_000;

endpackage

// File: rtl/c2c_ack_sync.sv
// c2c_ack_sync: two-flop synchronizer for the slave acknowledge.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset, clears both flops to 0
//   ack   in  acknowledge from the slave, asynchronous to clk
//   ack_s out synchronized acknowledge
module c2c_ack_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ack,
  output logic ack_s
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      meta  <= ack;
      ack_s <= meta;
    end
  end

endmodule

// File: rtl/c2c_link_arbiter.sv
// c2c_link_arbiter: master-side controller sharing one chip-to-chip channel
// between N_REQ local requesters. Requests and data are latched per
// requester, arbitrated round-robin and sent with a four-phase handshake.
//   clk           in  system clock
//   rst_n         in  asynchronous active-low reset
//   req_i         in  per-requester one-cycle request pulses
//   data_i        in  per-requester data, slice k = [k*DATA_W +: DATA_W]
//   ack           in  slave acknowledge (asynchronous)
//   request2s     out link request to slave
//   valid         out data_to_slave is valid
//   data_to_slave out data driven on the link (holds when valid=0)
//   notice_master out one-cycle pulse on successful transfer
//   done_o        out one-cycle pulse, bit k = requester k completed
//   timeout_o     out one-cycle pulse, bit k = requester k timed out
//   grant_o       out index of the requester owning the link
//   busy          out FSM is not in IDLE
//
// state | meaning
// IDLE  | link free; grants the next pending requester, if any
// REQ   | request2s high, waiting for ack_s rise
// XFER  | valid high with data, waiting for ack_s fall
// DONE  | one-cycle completion pulse, frees requester and advances rr_ptr
module c2c_link_arbiter
  import c2c_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = C2C_DATA_W,
  parameter int TIMEOUT = C2C_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  input  logic                      ack,
  output logic                      request2s,
  output logic                      valid,
  output logic [DATA_W-1:0]         data_to_slave,
  output logic                      notice_master,
  output logic [N_REQ-1:0]          done_o,
  output logic [N_REQ-1:0]          timeout_o,
  output logic [$clog2(N_REQ)-1:0]  grant_o,
  output logic                      busy
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  // Abort fires in the TIMEOUT-th cycle of a state, so the wait lasts
  // exactly TIMEOUT cycles before the FSM returns to IDLE.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    pending_q;
  logic [DATA_W-1:0]   data_buf [N_REQ];
  logic [GW-1:0]       grant_q, rr_ptr_q, pick;
  logic [DATA_W-1:0]   data_q;
  logic [N_REQ-1:0]    timeout_q;
  logic [CW-1:0]       cnt_q;
  logic                ack_s;
  logic                cnt_hit;
  logic                load_grant, finish, abort;
  logic [N_REQ-1:0]    grant_oh, clr, accept;

  // First pending index at or after ptr, wrapping around.
  function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] p,
                                            input logic [GW-1:0] ptr);
    logic [GW-1:0] r;
    logic          found;
    int            idx;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && p[idx]) begin
        r     = GW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] i);
    if (int'(i) == N_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  c2c_ack_sync u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ack   (ack),
    .ack_s (ack_s)
  );

  assign pick     = rr_pick(pending_q, rr_ptr_q);
  assign cnt_hit  = (cnt_q >= CNT_LAST);
  assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

  always_comb begin
    state_d    = state_q;
    load_grant = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          load_grant = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d = XFER;
        end else if (cnt_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      XFER: begin
        if (!ack_s) begin
          state_d = DONE;
        end else if (cnt_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pulse in the same cycle the granted bit clears is taken as a new request.
  assign clr    = (finish || abort) ? grant_oh : '0;
  assign accept = req_i & (~pending_q | clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      data_q    <= '0;
      timeout_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= (pending_q & ~clr) | accept;
      timeout_q <= abort ? grant_oh : '0;
      if (load_grant) begin
        grant_q <= pick;
        data_q  <= data_buf[pick];
      end
      if (finish || abort) begin
        rr_ptr_q <= wrap_inc(grant_q);
      end
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_REQ; k++) data_buf[k] <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (accept[k]) data_buf[k] <= data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign request2s     = (state_q == REQ);
  assign valid         = (state_q == XFER);
  assign notice_master = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign done_o        = finish ? grant_oh : '0;
  assign timeout_o     = timeout_q;
  assign grant_o       = grant_q;
  assign data_to_slave = data_q;

endmodule

// File: tb/tb_c2c_link_arbiter.sv
module tb_c2c_link_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_i;
  logic [5:0] data_i;
  logic       ack;
  logic       request2s, valid, notice_master, busy;
  logic [2:0] data_to_slave;
  logic [1:0] done_o, timeout_o;
  logic [0:0] grant_o;

  c2c_link_arbiter #(.N_REQ(2), .DATA_W(3), .TIMEOUT(50)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .data_i        (data_i),
    .ack           (ack),
    .request2s     (request2s),
    .valid         (valid),
    .data_to_slave (data_to_slave),
    .notice_master (notice_master),
    .done_o        (done_o),
    .timeout_o     (timeout_o),
    .grant_o       (grant_o),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         g;
    logic [2:0] d;
    bit         is_to;
  } exp_t;

  typedef struct {
    logic [1:0] mask;
    logic [2:0] d0;
    logic [2:0] d1;
    int         first;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   slave_en = 1'b1;
  bit   nprev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int g, input logic [2:0] d, input bit is_to);
    exp_t e;
    e.g = g; e.d = d; e.is_to = is_to;
    sb.push_back(e);
  endtask

  // Called at a negedge; request is sampled by the following posedge.
  task automatic pulse(input logic [1:0] m, input logic [2:0] d0, input logic [2:0] d1);
    req_i  = m;
    data_i = {d1, d0};
    @(negedge clk);
    req_i  = 2'b00;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Slave: raise ack 5 cycles after request2s, drop it 5 cycles after valid.
  always begin
    @(posedge clk);
    if (slave_en && rst_n && request2s && !ack) begin
      for (int i = 0; i < 5 && rst_n; i++) @(posedge clk);
      #1 ack = rst_n;
      for (int i = 0; i < 200 && rst_n && !valid; i++) @(posedge clk);
      for (int i = 0; i < 5 && rst_n; i++) @(posedge clk);
      #1 ack = 1'b0;
    end
  end

  // Scoreboard monitor: each completion/timeout pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      nprev = 1'b0;
    end else begin
      if (nprev) begin
        chk("idle_after_done_busy", busy, 0);
        chk("notice_width", notice_master, 0);
      end
      if (notice_master || timeout_o != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", {notice_master, timeout_o}, 0);
        end else begin
          e = sb.pop_front();
          if (e.is_to) begin
            chk("timeout_vec", timeout_o, 2'b01 << e.g);
            chk("timeout_no_notice", notice_master, 0);
          end else begin
            chk("done_vec", done_o, 2'b01 << e.g);
            chk("done_grant", grant_o, e.g);
            chk("done_data", data_to_slave, e.d);
            chk("done_no_timeout", timeout_o, 0);
          end
        end
      end
      nprev = notice_master;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    int   cnt;
    int   gm;
    bit   seen;
    logic [2:0] nd;

    tbl[0] = '{mask: 2'b01, d0: 3'd5, d1: 3'd0, first: 0};
    tbl[1] = '{mask: 2'b10, d0: 3'd0, d1: 3'd3, first: 1};
    tbl[2] = '{mask: 2'b11, d0: 3'd1, d1: 3'd6, first: 0};
    tbl[3] = '{mask: 2'b11, d0: 3'd7, d1: 3'd2, first: 0};
    tbl[4] = '{mask: 2'b10, d0: 3'd0, d1: 3'd4, first: 1};
    tbl[5] = '{mask: 2'b01, d0: 3'd2, d1: 3'd0, first: 0};
    tbl[6] = '{mask: 2'b11, d0: 3'd6, d1: 3'd5, first: 1};

    rst_n  = 1'b0;
    req_i  = 2'b00;
    data_i = 6'd0;
    ack    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_request2s", request2s, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {notice_master, done_o, timeout_o}, 0);
    chk("rst_grant_data", {grant_o, data_to_slave}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven transfers; rr order after reset is encoded in 'first'.
    for (int k = 0; k < 7; k++) begin
      v = tbl[k];
      push(v.first, (v.first == 1) ? v.d1 : v.d0, 1'b0);
      if (v.mask == 2'b11)
        push(1 - v.first, (v.first == 1) ? v.d0 : v.d1, 1'b0);
      pulse(v.mask, v.d0, v.d1);
      chk("lat_t1_request2s", request2s, 0);
      @(negedge clk);
      chk("lat_t2_request2s", request2s, 1);
      chk("lat_t2_grant", grant_o, v.first);
      drain(1000);
      repeat (2) @(negedge clk);
      chk("vec_end_busy", busy, 0);
    end

    // Timeout: slave silent, request2s held for exactly TIMEOUT cycles.
    slave_en = 1'b0;
    push(0, 3'd0, 1'b1);
    pulse(2'b01, 3'd3, 3'd0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (request2s) cnt++;
      else if (cnt > 0) break;
    end
    chk("to_req_cycles", cnt, 50);
    chk("to_busy", busy, 0);
    chk("to_pulse", timeout_o, 2'b01);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("to_pending_cleared", cnt, 0);
    slave_en = 1'b1;
    drain(10);

    // Repeated pulse while pending must not overwrite the captured data.
    push(1, 3'd2, 1'b0);
    pulse(2'b10, 3'd0, 3'd2);
    repeat (3) @(negedge clk);
    pulse(2'b10, 3'd0, 3'd7);
    drain(1000);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("ignored_pulse_no_retx", cnt, 0);

    // Back-to-back: re-pulse the granted requester in its DONE cycle.
    push(0, 3'd1, 1'b0);
    push(1, 3'd6, 1'b0);
    pulse(2'b11, 3'd1, 3'd6);
    gm = 0;
    for (int r = 0; r < 6; r++) begin
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (notice_master) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("b2b_notice_seen", seen, 1);
      if (!seen) break;
      chk("b2b_grant", grant_o, gm);
      if (r < 4) begin
        nd = 3'(r + 2);
        push(gm, nd, 1'b0);
        if (gm == 0) pulse(2'b01, nd, 3'd0);
        else         pulse(2'b10, 3'd0, nd);
      end else begin
        @(negedge clk);
      end
      gm = 1 - gm;
    end
    drain(1000);
    repeat (3) @(negedge clk);

    // Asynchronous reset during XFER discards the pending transfer.
    pulse(2'b01, 3'd3, 3'd0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_mid_valid_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_request2s", request2s, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_data", data_to_slave, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (request2s || busy) cnt++;
    end
    chk("rst_no_restart", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/c2c_link_arbiter.md
# c2c_link_arbiter

Master-side link controller that shares the single chip-to-chip channel (request2s / ack / valid / 3-bit data) between several local requesters. It latches per-requester requests and data, arbitrates round-robin and runs the four-phase handshake with the slave. It also reports completion or timeout per requester. It sits between the debounced/one-pulsed button logic and the link pins, in place of a single-requester master control.

## Interface
- N_REQ, 2, number of local requesters (2..4)
- DATA_W, 3, encoded data width on the link
- TIMEOUT, 1_000_000, cycles to wait for ack rise (or ack fall) before aborting
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_i  in  N_REQ  single-cycle request pulses, already debounced and one-pulsed
- data_i  in  N_REQ*DATA_W  per-requester encoded data; slice k is bits [k*DATA_W +: DATA_W]
- ack  in  1  slave acknowledge, asynchronous to clk
- request2s  out  1  link request to slave
- valid  out  1  data_to_slave is valid
- data_to_slave  out  DATA_W  data driven on the link
- notice_master  out  1  one-cycle pulse on successful transfer
- done_o  out  N_REQ  one-cycle pulse, bit k = requester k transfer completed
- timeout_o  out  N_REQ  one-cycle pulse, bit k = requester k aborted by timeout
- grant_o  out  $clog2(N_REQ)  index of the requester currently owning the link
- busy  out  1  high in any state other than IDLE

## Operation
- Pending latch per requester:
  - A req_i[k] pulse with pending[k]=0 sets pending[k] and captures data_i slice k into buf[k].
  - A pulse while pending[k]=1 is ignored; buf is not overwritten.
- pending[k] clears when requester k completes or times out.
- ack passes through a 2-FF synchronizer; only the synchronized ack (ack_s) is used.
- FSM states: IDLE, REQ, XFER, DONE.
  - IDLE: if any pending bit is set, pick the first pending index at or after rr_ptr (wrapping), register grant_o and data_to_slave = buf[grant], then go to REQ. Otherwise stay in IDLE.
  - REQ: request2s=1. On ack_s=1, go to XFER. If the counter reaches TIMEOUT, pulse timeout_o[grant], clear pending[grant] and go to IDLE.
  - XFER: request2s=0, valid=1, data_to_slave held. On ack_s=0, go to DONE. If the counter reaches TIMEOUT, take the same timeout action as in REQ.
  - DONE: pulse notice_master and done_o[grant], clear pending[grant], set rr_ptr = grant+1 mod N_REQ, go to IDLE.
- rr_ptr also advances past the granted index on timeout.
- A new req_i pulse for the granted requester in the same cycle its pending bit clears is accepted and sets pending again.
- The counter is $clog2(TIMEOUT+1) bits wide, clears on every state entry and saturates at TIMEOUT.
- data_to_slave keeps its last value when valid=0.

## Timing
- Reset values:
  - request2s, valid, notice_master, busy: 0
  - done_o, timeout_o, pending: all zero
  - grant_o, rr_ptr, data_to_slave: 0
  - FSM in IDLE
- req_i pulse in cycle t: pending is visible at t+1, the IDLE grant decision is made in t+1, and request2s=1 from t+2.
- An external ack edge reaches ack_s 2–3 cycles later. The FSM reacts in the cycle after ack_s changes.
- notice_master and done_o are exactly 1 cycle wide; the FSM is back in IDLE the following cycle.
- There is a minimum of one IDLE cycle between back-to-back transfers.
- Simultaneous req_i on several requesters: all are latched; service follows round-robin order.
- rst_n asserted mid-transfer: all outputs return to reset values immediately (asynchronously), and pending requests are discarded.

## Structure
- Package c2c_pkg holds:
  - the state enum (IDLE, REQ, XFER, DONE)
  - DATA_W default
  - the default TIMEOUT constant, shared with the slave-side controller
- One sub-module: c2c_ack_sync, a 2-FF synchronizer with asynchronous active-low reset to 0.
- The round-robin pick is a combinational function within the block.

## Test plan
- TIMEOUT=50, N_REQ=2. Pulse req_i[0] with data 3'b101; slave raises ack 5 cycles after request2s and drops it 5 cycles after valid -> request2s, then valid with data_to_slave=5, then one-cycle notice_master and done_o=2'b01.
- Pulse req_i[0] and req_i[1] in the same cycle (data 1 and 6) -> requester 0 served first with data 1, requester 1 next with data 6; grant_o goes 0 then 1.
- Slave never acks -> request2s high for 50 cycles, then timeout_o[grant] pulse, request2s=0, busy=0, pending cleared.
- Second req_i[1] pulse with new data while requester 1 is pending -> the originally captured data is transmitted.
- Assert rst_n=0 during XFER -> valid, request2s and busy go to 0 without waiting for clk; after release, no transfer starts without a new req_i.
- Three back-to-back rounds with both requesters always pending -> grants alternate 0,1,0,1,… with one IDLE cycle between transfers.
